cam_pixel_capture: RTL and testbench

Capture front end for the OV7670 path, operating in the camera pixel-clock domain. It samples the camera's VSYNC/HREF/D[7:0] bus and assembles RGB444 pixels from byte pairs. It generates a linear frame-buffer address and issues single-cycle BRAM write strobes. It is the writer into the dual-port frame BRAM whose read side is scanned by the VGA display path. Both sides use the same addressing: `addr = y*640 + x`, RGB444 packed as {R,G,B}.

---
 rtl/cam_pixel_capture.sv | 194 +++++++++++++++++++
 tb/tb_cam_pixel_capture.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_pixel_capture.sv
// cam_pixel_capture: OV7670 capture front end in the camera pixel-clock domain.
// Registers VSYNC/HREF/D, assembles RGB444 pixels from byte pairs and writes
// them into the frame BRAM at addr = y*H_PIXELS + x, one write per pixel.
// Optional feature macro: CAM_LINE_CHECK_EN. When defined, each captured line
// is checked for exactly H_PIXELS pixels and o_line_err latches any mismatch.
// When undefined, o_line_err is tied to 0.
// Handshake: there is no back-pressure. o_pix_wr is a single-cycle strobe, and
// o_pix_addr/o_pix_data are valid in that cycle and hold otherwise.
module cam_pixel_capture #(
  parameter int H_PIXELS    = 640,
  parameter int V_LINES     = 480,
  parameter int SKIP_FRAMES = 2    // 0..255
) (
  input  logic        i_pclk,
  input  logic        i_rstn_pclk,
  input  logic        i_cam_vsync,
  input  logic        i_cam_href,
  input  logic [7:0]  i_cam_data,
  output logic        o_pix_wr,
  output logic [18:0] o_pix_addr,
  output logic [11:0] o_pix_data,
  output logic        o_frame_done,
  output logic        o_capturing,
  output logic        o_line_err
);

  typedef enum logic [1:0] {ST_SKIP, ST_IDLE, ST_CAPTURE} state_t;

  localparam logic [18:0] MAX_ADDR  = 19'(H_PIXELS * V_LINES - 1);
  localparam logic [7:0]  SKIP_LAST = 8'(SKIP_FRAMES - 1);
  localparam state_t      RST_STATE = (SKIP_FRAMES == 0) ? ST_IDLE : ST_SKIP;

  logic        vsync_r_q, vsync_r_d;
  logic        vsync_rr_q, vsync_rr_d;
  logic        href_r_q, href_r_d;
  logic [7:0]  data_r_q, data_r_d;
  state_t      state_q, state_d;
  logic [7:0]  skip_cnt_q, skip_cnt_d;
  logic        phase_q, phase_d;
  logic [3:0]  red_q, red_d;
  logic [18:0] addr_cnt_q, addr_cnt_d;
  logic        full_q, full_d;
  logic        pix_wr_q, pix_wr_d;
  logic [18:0] pix_addr_q, pix_addr_d;
  logic [11:0] pix_data_q, pix_data_d;
  logic        frame_done_q, frame_done_d;
  logic        capturing_q, capturing_d;
  logic        vsync_rise, vsync_fall;

  assign vsync_rise = vsync_r_q & ~vsync_rr_q;
  assign vsync_fall = ~vsync_r_q & vsync_rr_q;

  // Next-state logic: input stage, skip counting, byte pairing and addressing.
  always_comb begin
    vsync_r_d    = i_cam_vsync;
    vsync_rr_d   = vsync_r_q;
    href_r_d     = i_cam_href;
    data_r_d     = i_cam_data;
    state_d      = state_q;
    skip_cnt_d   = skip_cnt_q;
    phase_d      = phase_q;
    red_d        = red_q;
    addr_cnt_d   = addr_cnt_q;
    full_d       = full_q;
    pix_wr_d     = 1'b0;
    pix_addr_d   = pix_addr_q;
    pix_data_d   = pix_data_q;
    frame_done_d = 1'b0;
    case (state_q)
      ST_SKIP: begin
        if (vsync_rise) begin
          if (skip_cnt_q == SKIP_LAST) state_d = ST_IDLE;
          else skip_cnt_d = skip_cnt_q + 8'd1;
        end
      end
      ST_IDLE: begin
        if (vsync_fall) begin
          addr_cnt_d = '0;
          full_d     = 1'b0;
          phase_d    = 1'b0;
          state_d    = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        // A VSYNC rise ends the frame and discards any byte seen with it.
        if (vsync_rise) begin
          frame_done_d = 1'b1;
          phase_d      = 1'b0;
          state_d      = ST_IDLE;
        end else if (href_r_q) begin
          phase_d = ~phase_q;
          if (!phase_q) begin
            red_d = data_r_q[3:0];
          end else if (!full_q) begin
            pix_wr_d   = 1'b1;
            pix_addr_d = addr_cnt_q;
            pix_data_d = {red_q, data_r_q};
            // No wrap: the last address seals the frame until the next start.
            if (addr_cnt_q == MAX_ADDR) full_d = 1'b1;
            else addr_cnt_d = addr_cnt_q + 19'd1;
          end
        end else begin
          phase_d = 1'b0;
        end
      end
      default: state_d = RST_STATE;
    endcase
    capturing_d = (state_d == ST_CAPTURE);
  end

  // State and output registers.
  always_ff @(posedge i_pclk or negedge i_rstn_pclk) begin
    if (!i_rstn_pclk) begin
      vsync_r_q    <= 1'b0;
      vsync_rr_q   <= 1'b0;
      href_r_q     <= 1'b0;
      data_r_q     <= '0;
      state_q      <= RST_STATE;
      skip_cnt_q   <= '0;
      phase_q      <= 1'b0;
      red_q        <= '0;
      addr_cnt_q   <= '0;
      full_q       <= 1'b0;
      pix_wr_q     <= 1'b0;
      pix_addr_q   <= '0;
      pix_data_q   <= '0;
      frame_done_q <= 1'b0;
      capturing_q  <= 1'b0;
    end else begin
      vsync_r_q    <= vsync_r_d;
      vsync_rr_q   <= vsync_rr_d;
      href_r_q     <= href_r_d;
      data_r_q     <= data_r_d;
      state_q      <= state_d;
      skip_cnt_q   <= skip_cnt_d;
      phase_q      <= phase_d;
      red_q        <= red_d;
      addr_cnt_q   <= addr_cnt_d;
      full_q       <= full_d;
      pix_wr_q     <= pix_wr_d;
      pix_addr_q   <= pix_addr_d;
      pix_data_q   <= pix_data_d;
      frame_done_q <= frame_done_d;
      capturing_q  <= capturing_d;
    end
  end

  assign o_pix_wr     = pix_wr_q;
  assign o_pix_addr   = pix_addr_q;
  assign o_pix_data   = pix_data_q;
  assign o_frame_done = frame_done_q;
  assign o_capturing  = capturing_q;

`ifdef CAM_LINE_CHECK_EN
  localparam logic [15:0] LINE_LEN = 16'(H_PIXELS);

  logic        href_rr_q, href_rr_d;
  logic [15:0] line_cnt_q, line_cnt_d;
  logic        line_err_q, line_err_d;
  logic        pix_seen;

  // Every completed byte pair in a line counts, even past the end of the frame.
  assign pix_seen = (state_q == ST_CAPTURE) & href_r_q & phase_q & ~vsync_rise;

  // Per-line pixel count, judged at the HREF falling edge.
  always_comb begin
    href_rr_d  = href_r_q;
    line_cnt_d = line_cnt_q;
    line_err_d = line_err_q;
    if (href_r_q && !href_rr_q) line_cnt_d = '0;
    else if (pix_seen) line_cnt_d = line_cnt_q + 16'd1;
    if (!href_r_q && href_rr_q && (state_q == ST_CAPTURE) && (line_cnt_q != LINE_LEN))
      line_err_d = 1'b1;
  end

  // Line-check registers; the error is sticky until reset.
  always_ff @(posedge i_pclk or negedge i_rstn_pclk) begin
    if (!i_rstn_pclk) begin
      href_rr_q  <= 1'b0;
      line_cnt_q <= '0;
      line_err_q <= 1'b0;
    end else begin
      href_rr_q  <= href_rr_d;
      line_cnt_q <= line_cnt_d;
      line_err_q <= line_err_d;
    end
  end

  assign o_line_err = line_err_q;
`else
  assign o_line_err = 1'b0;
`endif

endmodule

// File: tb/tb_cam_pixel_capture.sv
// Testbench for cam_pixel_capture with a small 8x4 frame and SKIP_FRAMES=2.
module tb_cam_pixel_capture;
  localparam int H    = 8;
  localparam int V    = 4;
  localparam int MAXA = H * V - 1;
`ifdef CAM_LINE_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        vsync = 1'b0;
  logic        href  = 1'b0;
  logic [7:0]  data  = 8'h00;
  logic        pix_wr;
  logic [18:0] pix_addr;
  logic [11:0] pix_data;
  logic        frame_done;
  logic        capturing;
  logic        line_err;

  cam_pixel_capture #(.H_PIXELS(H), .V_LINES(V), .SKIP_FRAMES(2)) dut (
    .i_pclk(clk), .i_rstn_pclk(rst_n), .i_cam_vsync(vsync), .i_cam_href(href),
    .i_cam_data(data), .o_pix_wr(pix_wr), .o_pix_addr(pix_addr),
    .o_pix_data(pix_data), .o_frame_done(frame_done), .o_capturing(capturing),
    .o_line_err(line_err)
  );

  // scoreboard: {addr, data} per write
  logic [30:0] exp_q[$];
  logic [30:0] got_q[$];
  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int exp_addr = 0;
  bit exp_full = 1'b0;

  // monitor samples 1 time unit after the active edge
  always @(posedge clk) begin
    #1;
    if (pix_wr) got_q.push_back({pix_addr, pix_data});
    if (frame_done) done_cnt++;
  end

  // driver tasks
  task automatic put(input logic v, input logic h, input logic [7:0] d);
    vsync = v; href = h; data = d;
  endtask

  task automatic drive(input logic v, input logic h, input logic [7:0] d);
    @(negedge clk);
    put(v, h, d);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic clear_sb();
    exp_q.delete(); got_q.delete(); done_cnt = 0; exp_addr = 0; exp_full = 1'b0;
  endtask

  task automatic push_exp(input logic [11:0] px);
    if (!exp_full) begin
      exp_q.push_back({19'(exp_addr), px});
      if (exp_addr == MAXA) exp_full = 1'b1;
      else exp_addr++;
    end
  endtask

  task automatic send_line(input int nbytes, input bit rec);
    logic [11:0] px;
    px = '0;
    for (int b = 0; b < nbytes; b++) begin
      if (b % 2 == 0) begin
        px = 12'($urandom_range(0, 4095));
        drive(1'b0, 1'b1, {4'($urandom_range(0, 15)), px[11:8]});
      end else begin
        drive(1'b0, 1'b1, px[7:0]);
        if (rec) push_exp(px);
      end
    end
    idle(3);
  endtask

  task automatic send_frame(input int lines, input bit rec);
    for (int l = 0; l < lines; l++) send_line(2 * H, rec);
  endtask

  task automatic vsync_pulse();
    repeat (4) drive(1'b1, 1'b0, 8'h00);
    idle(4);
  endtask

  task automatic test_reset();
    #25;
    checks++; if (pix_wr !== 1'b0) begin failures++; $display("FAIL rst_wr got=%b exp=0", pix_wr); end
    checks++; if (pix_addr !== 19'd0) begin failures++; $display("FAIL rst_addr got=%0d exp=0", pix_addr); end
    checks++; if (pix_data !== 12'h000) begin failures++; $display("FAIL rst_data got=%h exp=000", pix_data); end
    checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", frame_done); end
    checks++; if (capturing !== 1'b0) begin failures++; $display("FAIL rst_capturing got=%b exp=0", capturing); end
    checks++; if (line_err !== 1'b0) begin failures++; $display("FAIL rst_line_err got=%b exp=0", line_err); end
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_skip_frames();
    clear_sb();
    send_frame(V, 1'b0);
    vsync_pulse();
    checks++; if (capturing !== 1'b0) begin failures++; $display("FAIL skip_cap1 got=%b exp=0", capturing); end
    send_frame(V, 1'b0);
    vsync_pulse();
    checks++; if (capturing !== 1'b1) begin failures++; $display("FAIL skip_cap2 got=%b exp=1", capturing); end
    checks++; if (got_q.size() != 0) begin failures++; $display("FAIL skip_no_wr got=%0d exp=0", got_q.size()); end
    checks++; if (done_cnt != 0) begin failures++; $display("FAIL skip_no_done got=%0d exp=0", done_cnt); end
    clear_sb();
    send_frame(V, 1'b1);
    vsync_pulse();
    checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL skip_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL skip_pix[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL skip_done got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_byte_packing();
    logic [11:0] px;
    clear_sb();
    push_exp(12'hA5C);
    drive(1'b0, 1'b1, 8'h0A);
    drive(1'b0, 1'b1, 8'h5C);
    @(negedge clk);
    checks++; if (pix_wr !== 1'b0) begin failures++; $display("FAIL pack_early got=%b exp=0", pix_wr); end
    px = 12'h3C7;
    put(1'b0, 1'b1, {4'h9, px[11:8]});
    @(negedge clk);
    checks++; if (pix_wr !== 1'b1) begin failures++; $display("FAIL pack_wr got=%b exp=1", pix_wr); end
    checks++; if (pix_addr !== 19'd0) begin failures++; $display("FAIL pack_addr got=%0d exp=0", pix_addr); end
    checks++; if (pix_data !== 12'hA5C) begin failures++; $display("FAIL pack_data got=%h exp=a5c", pix_data); end
    put(1'b0, 1'b1, px[7:0]);
    push_exp(px);
    @(negedge clk);
    checks++; if (pix_wr !== 1'b0) begin failures++; $display("FAIL pack_one_cycle got=%b exp=0", pix_wr); end
    checks++; if (pix_addr !== 19'd0 || pix_data !== 12'hA5C) begin
      failures++; $display("FAIL pack_hold got=%0d/%h exp=0/a5c", pix_addr, pix_data);
    end
    px = 12'h4E1;
    put(1'b0, 1'b1, {4'h0, px[11:8]});
    @(negedge clk);
    put(1'b0, 1'b1, px[7:0]);
    push_exp(px);
    for (int p = 3; p < H; p++) begin
      px = 12'($urandom_range(0, 4095));
      drive(1'b0, 1'b1, {4'hF, px[11:8]});
      drive(1'b0, 1'b1, px[7:0]);
      push_exp(px);
    end
    idle(3);
    send_frame(V - 1, 1'b1);
    vsync_pulse();
    checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL pack_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL pack_pix[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL pack_done got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_odd_bytes();
    clear_sb();
    send_line(2 * H + 1, 1'b1);
    send_line(2 * H, 1'b1);
    send_frame(V - 2, 1'b1);
    vsync_pulse();
    checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL odd_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL odd_pix[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL odd_done got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_overrun();
    clear_sb();
    send_frame(V + 1, 1'b1);
    vsync_pulse();
    checks++; if (got_q.size() != H * V) begin failures++; $display("FAIL ovr_count got=%0d exp=%0d", got_q.size(), H * V); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL ovr_pix[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (pix_addr !== 19'(MAXA)) begin failures++; $display("FAIL ovr_addr_hold got=%0d exp=%0d", pix_addr, MAXA); end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL ovr_done got=%0d exp=1", done_cnt); end
    checks++; if (line_err !== 1'b0) begin failures++; $display("FAIL ovr_line_err got=%b exp=0", line_err); end
  endtask

  task automatic test_vsync_collision();
    clear_sb();
    send_frame(1, 1'b1);
    drive(1'b0, 1'b1, 8'h07);
    drive(1'b1, 1'b1, 8'hE2);
    repeat (3) drive(1'b1, 1'b0, 8'h00);
    idle(4);
    checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL coll_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL coll_pix[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL coll_done got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_short_frame();
    clear_sb();
    send_frame(2, 1'b1);
    vsync_pulse();
    checks++; if (got_q.size() != 2 * H) begin failures++; $display("FAIL short_count got=%0d exp=%0d", got_q.size(), 2 * H); end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL short_done got=%0d exp=1", done_cnt); end
    clear_sb();
    send_frame(1, 1'b1);
    vsync_pulse();
    checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL restart_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL restart_pix[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid_line();
    clear_sb();
    drive(1'b0, 1'b1, 8'h51);
    drive(1'b0, 1'b1, 8'h23);
    drive(1'b0, 1'b1, 8'hAF);
    drive(1'b0, 1'b1, 8'hFF);
    @(negedge clk);
    put(1'b0, 1'b1, 8'h06);
    @(negedge clk);
    checks++; if (pix_wr !== 1'b1 || pix_addr !== 19'd1 || pix_data !== 12'hFFF) begin
      failures++; $display("FAIL midline_pre got=%b/%0d/%h exp=1/1/fff", pix_wr, pix_addr, pix_data);
    end
    rst_n = 1'b0;
    #1;
    checks++; if (pix_wr !== 1'b0) begin failures++; $display("FAIL mrst_wr got=%b exp=0", pix_wr); end
    checks++; if (pix_addr !== 19'd0) begin failures++; $display("FAIL mrst_addr got=%0d exp=0", pix_addr); end
    checks++; if (pix_data !== 12'h000) begin failures++; $display("FAIL mrst_data got=%h exp=000", pix_data); end
    checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL mrst_done got=%b exp=0", frame_done); end
    checks++; if (capturing !== 1'b0) begin failures++; $display("FAIL mrst_capturing got=%b exp=0", capturing); end
    checks++; if (line_err !== 1'b0) begin failures++; $display("FAIL mrst_line_err got=%b exp=0", line_err); end
    put(1'b0, 1'b0, 8'h00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    vsync_pulse();
    checks++; if (capturing !== 1'b0) begin failures++; $display("FAIL mrst_reskip got=%b exp=0", capturing); end
    vsync_pulse();
    checks++; if (capturing !== 1'b1) begin failures++; $display("FAIL mrst_resume got=%b exp=1", capturing); end
    clear_sb();
    send_frame(V, 1'b1);
    vsync_pulse();
    checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL mrst_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL mrst_pix[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL mrst_done_pulse got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_line_check();
    clear_sb();
    send_line(2 * H - 2, 1'b1);
    checks++; if (line_err !== EXP_ERR) begin failures++; $display("FAIL lchk_set got=%b exp=%b", line_err, EXP_ERR); end
    send_frame(V - 1, 1'b1);
    vsync_pulse();
    send_frame(V, 1'b1);
    vsync_pulse();
    checks++; if (line_err !== EXP_ERR) begin failures++; $display("FAIL lchk_sticky got=%b exp=%b", line_err, EXP_ERR); end
    checks++; if (done_cnt != 2) begin failures++; $display("FAIL lchk_done got=%0d exp=2", done_cnt); end
  endtask

  initial begin
    test_reset();
    test_skip_frames();
    test_byte_packing();
    test_odd_bytes();
    test_overrun();
    test_vsync_collision();
    test_short_frame();
    test_reset_mid_line();
    test_line_check();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
